image_transmitter: RTL and testbench
====================================

Name: image_transmitter

Overview:
- Outbound counterpart of image_receiver. After Sobel processing completes, it reads 8-bit edge pixels back from SRAM and formats them as a 24-bit BMP byte stream.
- The stream is sliced into fixed-size blocks. For each full block, it requests an SD block write from the SD card interface.
- Sits between controller/SRAM and the SD_Card_Interface write path (getData/fifo_data side).

Parameters:
- BLOCK_BYTES, 512, bytes per SD write block.
- ADDR_W, 16, SRAM address width.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse that begins a transfer; ignored while busy
- img_width  in  16  pixels per row
- img_height  in  16  rows
- base_address  in  ADDR_W  SRAM address of pixel 0
- w_start_addr  in  32  SD block address of the first block
- sram_read  out  1  SRAM read strobe
- sram_address  out  ADDR_W  SRAM read address
- sram_data  in  8  SRAM read data, valid the cycle after sram_read
- out_byte  out  8  stream byte to the SD interface
- out_valid  out  1  out_byte valid
- out_ready  in  1  SD interface accepts out_byte
- sd_write  out  1  one-cycle block write request
- sd_block_addr  out  32  block address; held valid from sd_write until the flush completes
- sd_hold  in  1  SD interface busy with the current command
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the final block flush
- error  out  1  one-cycle pulse when start arrives with a zero dimension

Behaviour:
- Reset (n_rst=0 at a clk edge): state IDLE; all outputs 0; all counters 0. Applies mid-transfer with no block flush and no done pulse.
- Clock and reset ports are clk and n_rst. One clock domain. Reset is synchronous, active-low.
- Derived values, computed once at start:
  - row_bytes = ((3*img_width + 3) >> 2) << 2
  - pad = row_bytes - 3*img_width
  - img_bytes = row_bytes*img_height
  - file_size = 54 + img_bytes
  - all 32-bit, unsigned
- States:
  - IDLE
  - HDR
  - RD
  - RDW
  - EMIT
  - PAD
  - FILL
  - FLUSH
  - WAIT_HI
  - WAIT_LO
  - FIN
- IDLE:
  - start with img_width==0 or img_height==0: pulse error, stay in IDLE.
  - otherwise: latch inputs, set busy=1, go to HDR.
- HDR: emits 54 header bytes, little-endian fields:
  - 'B','M'
  - file_size
  - 0 (reserved, 4 bytes)
  - 54 (pixel offset)
  - 40 (DIB size)
  - width (32-bit)
  - height (32-bit)
  - 1 (planes, 16-bit)
  - 24 (bpp, 16-bit)
  - 0 (compression)
  - img_bytes
  - 2835
  - 2835
  - 0
  - 0
- RD: sram_read=1 for exactly one cycle with sram_address = base_address + pixel_index. Then RDW latches sram_data.
- EMIT: outputs the latched gray byte three times (B,G,R).
- Row end: after the last pixel of a row, go to PAD and emit pad zero bytes, skipped if pad==0.
- Pixel order: pixel_index 0..width*height-1, linear. A new row starts when the column counter wraps.
- Stream handshake:
  - A byte transfers on a cycle with out_valid & out_ready.
  - out_byte is held stable while out_valid & !out_ready.
  - The block byte counter increments only on a transfer.
- Block full: when the counter reaches BLOCK_BYTES after a transfer, the counter wraps to 0 and the block is flushed from any emitting state. The interrupted state and its sub-counters are saved and resumed afterward.
- Flush sequence:
  - out_valid=0.
  - FLUSH: sd_write=1 for one cycle, sd_block_addr = w_start_addr + block_idx.
  - WAIT_HI: wait for sd_hold=1.
  - WAIT_LO: wait for sd_hold=0.
  - Then block_idx++ and resume.
- End of stream:
  - After the last byte: if the block counter is nonzero, FILL emits zeros up to BLOCK_BYTES, then flushes.
  - If the counter is already 0 (the last transfer completed a block and its flush is done), go straight to FIN.
- FIN: done pulse for 1 cycle, busy=0, go to IDLE.
- A block-full condition and the end of the image on the same transfer cause exactly one flush; FILL is skipped.

Optional Feature:
- IMG_TX_HEADER_EN.
- Defined: HDR state emits the 54-byte BMP header as above.
- Undefined: HDR is omitted; IDLE goes straight to RD. The stream contains only pixel and pad bytes, and block count is based on img_bytes alone.

Test Plan:
- Dimensions 4x2, out_ready=1, base 0x0100, SRAM = index value:
  - 78 meaningful bytes; header bytes 2..5 = 4E 00 00 00.
  - Byte 54 = 00,00,00, then 01,01,01.
  - Zero-filled to 512; one sd_write with sd_block_addr = w_start_addr; then done.
- Dimensions 3x1: row_bytes 12, pad 3; bytes 63..65 = 00 after 9 pixel bytes; header bytes 34..37 = 0C 00 00 00.
- Dimensions 100x2, w_start_addr 5000:
  - 654 bytes, two sd_write pulses at addresses 5000 and 5001.
  - Second pulse only after sd_hold rises and then falls for the first.
- Random out_ready backpressure on 4x2: byte sequence identical to the first test; out_byte stable during stalls.
- start with width 0: error pulse, busy stays 0, no sram_read. start asserted while busy: ignored.
- n_rst low during EMIT of 100x2: next cycle all outputs 0. A subsequent start of 4x2 reproduces the first test exactly.

Source files
------------

// File: rtl/image_transmitter.sv
// image_transmitter: reads 8-bit gray pixels back from SRAM and streams them
// as 24-bit BMP bytes, cut into BLOCK_BYTES-sized SD write blocks.
// Build macro IMG_TX_HEADER_EN: when defined, the 54-byte BMP header is
// emitted ahead of the pixel data; otherwise the stream is pixels + pad only.
module image_transmitter #(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [15:0]       img_width,
    input  logic [15:0]       img_height,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [31:0]       w_start_addr,
    output logic              sram_read,
    output logic [ADDR_W-1:0] sram_address,
    input  logic [7:0]        sram_data,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sd_write,
    output logic [31:0]       sd_block_addr,
    input  logic              sd_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = $clog2(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLOCK_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, HDR, RD, RDW, EMIT, PAD, FILL, FLUSH, WAIT_HI, WAIT_LO, FIN
    } state_t;

    state_t            state;
    state_t            ret_state;
    logic [15:0]       width_r;
    logic [31:0]       npix_r;
    logic [ADDR_W-1:0] base_r;
    logic [31:0]       wstart_r;
    logic [1:0]        pad_r;
    logic [7:0]        gray;
    logic [15:0]       col;
    logic [31:0]       pix_idx;
    logic [1:0]        rgb;
    logic [1:0]        pad_cnt;
    logic [CNT_W-1:0]  blk_cnt;
    logic [31:0]       block_idx;

    logic              xfer;
    logic              blk_full;
    logic [1:0]        pad_c;
    logic [31:0]       npix_c;

    state_t            nx_state;
    logic [7:0]        nx_byte;
    logic              nx_end;
    logic [1:0]        nx_rgb;
    logic [1:0]        nx_pad;
    logic [15:0]       nx_col;
    logic [31:0]       nx_pix;

`ifdef IMG_TX_HEADER_EN
    logic [5:0]        hdr_idx;
    logic [5:0]        nx_hdr;
    logic [15:0]       height_r;
    logic [31:0]       file_size_r;
    logic [31:0]       img_bytes_r;
    logic [31:0]       row_bytes_c;
    logic [31:0]       img_bytes_c;

    // Header byte idx; fields from offset 2 onward are 32-bit aligned
    // little-endian words (planes/bpp share one word).
    function automatic logic [7:0] hdr_byte(
        input logic [5:0]  idx,
        input logic [31:0] fsize,
        input logic [15:0] w,
        input logic [15:0] h,
        input logic [31:0] ibytes
    );
        logic [5:0]  k;
        logic [31:0] field;
        k = idx - 6'd2;
        case (k[5:2])
            4'd0:        field = fsize;
            4'd2:        field = 32'd54;
            4'd3:        field = 32'd40;
            4'd4:        field = {16'd0, w};
            4'd5:        field = {16'd0, h};
            4'd6:        field = {16'd24, 16'd1};
            4'd8:        field = ibytes;
            4'd9, 4'd10: field = 32'd2835;
            default:     field = 32'd0;
        endcase
        if (idx == 6'd0) return 8'h42;
        if (idx == 6'd1) return 8'h4D;
        return field[{k[1:0], 3'b000} +: 8];
    endfunction

    assign row_bytes_c = 32'(img_width) * 32'd3 + 32'(pad_c);
    assign img_bytes_c = row_bytes_c * 32'(img_height);
`endif

    assign xfer     = out_valid & out_ready;
    assign blk_full = (blk_cnt == BLK_LAST);
    // Row padding is (-3*width) mod 4, which only depends on width[1:0].
    assign pad_c    = 2'd0 - (img_width[1:0] * 2'd3);
    assign npix_c   = 32'(img_width) * 32'(img_height);

    // Position and byte that follow the byte currently on out_byte.
    always_comb begin
        nx_state = state;
        nx_byte  = 8'h00;
        nx_end   = 1'b0;
        nx_rgb   = rgb;
        nx_pad   = pad_cnt;
        nx_col   = col;
        nx_pix   = pix_idx;
`ifdef IMG_TX_HEADER_EN
        nx_hdr   = hdr_idx;
`endif
        case (state)
`ifdef IMG_TX_HEADER_EN
            HDR: begin
                if (hdr_idx != 6'd53) begin
                    nx_hdr  = hdr_idx + 6'd1;
                    nx_byte = hdr_byte(hdr_idx + 6'd1, file_size_r, width_r,
                                       height_r, img_bytes_r);
                end else begin
                    nx_state = RD;
                end
            end
`endif
            EMIT: begin
                if (rgb != 2'd2) begin
                    nx_rgb  = rgb + 2'd1;
                    nx_byte = gray;
                end else begin
                    nx_rgb = 2'd0;
                    nx_pix = pix_idx + 32'd1;
                    nx_col = (col == width_r - 16'd1) ? 16'd0 : col + 16'd1;
                    if (col == width_r - 16'd1 && pad_r != 2'd0) begin
                        nx_state = PAD;
                        nx_pad   = 2'd0;
                    end else if (pix_idx == npix_r - 32'd1) begin
                        nx_state = FILL;
                        nx_end   = 1'b1;
                    end else begin
                        nx_state = RD;
                    end
                end
            end
            PAD: begin
                if ((pad_cnt + 2'd1) != pad_r) begin
                    nx_pad = pad_cnt + 2'd1;
                end else if (pix_idx == npix_r) begin
                    nx_state = FILL;
                    nx_end   = 1'b1;
                end else begin
                    nx_state = RD;
                end
            end
            FILL: begin
                nx_end = 1'b1;
            end
            default: ;
        endcase
    end

    // Transfer FSM: all outputs registered; a full block parks the next
    // position in ret_state and the sub-counters, then resumes after flush.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= IDLE;
            ret_state     <= IDLE;
            width_r       <= '0;
            npix_r        <= '0;
            base_r        <= '0;
            wstart_r      <= '0;
            pad_r         <= '0;
            gray          <= '0;
            col           <= '0;
            pix_idx       <= '0;
            rgb           <= '0;
            pad_cnt       <= '0;
            blk_cnt       <= '0;
            block_idx     <= '0;
            sram_read     <= 1'b0;
            sram_address  <= '0;
            out_byte      <= '0;
            out_valid     <= 1'b0;
            sd_write      <= 1'b0;
            sd_block_addr <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
`ifdef IMG_TX_HEADER_EN
            hdr_idx       <= '0;
            height_r      <= '0;
            file_size_r   <= '0;
            img_bytes_r   <= '0;
`endif
        end else begin
            sram_read <= 1'b0;
            sd_write  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (img_width == 16'd0 || img_height == 16'd0) begin
                            error <= 1'b1;
                        end else begin
                            busy      <= 1'b1;
                            width_r   <= img_width;
                            npix_r    <= npix_c;
                            base_r    <= base_address;
                            wstart_r  <= w_start_addr;
                            pad_r     <= pad_c;
                            col       <= '0;
                            pix_idx   <= '0;
                            rgb       <= '0;
                            pad_cnt   <= '0;
                            blk_cnt   <= '0;
                            block_idx <= '0;
`ifdef IMG_TX_HEADER_EN
                            height_r    <= img_height;
                            file_size_r <= 32'd54 + img_bytes_c;
                            img_bytes_r <= img_bytes_c;
                            hdr_idx     <= '0;
                            out_byte    <= 8'h42;
                            out_valid   <= 1'b1;
                            state       <= HDR;
`else
                            sram_read    <= 1'b1;
                            sram_address <= base_address;
                            state        <= RD;
`endif
                        end
                    end
                end
                HDR, EMIT, PAD, FILL: begin
                    if (xfer) begin
                        blk_cnt  <= blk_full ? '0 : blk_cnt + CNT_W'(1);
                        rgb      <= nx_rgb;
                        pad_cnt  <= nx_pad;
                        col      <= nx_col;
                        pix_idx  <= nx_pix;
                        out_byte <= nx_byte;
`ifdef IMG_TX_HEADER_EN
                        hdr_idx  <= nx_hdr;
`endif
                        if (blk_full) begin
                            out_valid     <= 1'b0;
                            sd_write      <= 1'b1;
                            sd_block_addr <= wstart_r + block_idx;
                            ret_state     <= nx_end ? FIN : nx_state;
                            state         <= FLUSH;
                        end else if (nx_state == RD) begin
                            out_valid    <= 1'b0;
                            sram_read    <= 1'b1;
                            sram_address <= base_r + nx_pix[ADDR_W-1:0];
                            state        <= RD;
                        end else begin
                            state <= nx_state;
                        end
                    end
                end
                RD: begin
                    state <= RDW;
                end
                RDW: begin
                    gray      <= sram_data;
                    out_byte  <= sram_data;
                    out_valid <= 1'b1;
                    rgb       <= 2'd0;
                    state     <= EMIT;
                end
                FLUSH: begin
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (sd_hold) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!sd_hold) begin
                        block_idx <= block_idx + 32'd1;
                        state     <= ret_state;
                        case (ret_state)
                            RD: begin
                                sram_read    <= 1'b1;
                                sram_address <= base_r + pix_idx[ADDR_W-1:0];
                            end
                            FIN: begin
                                done <= 1'b1;
                                busy <= 1'b0;
                            end
                            default: out_valid <= 1'b1;
                        endcase
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_transmitter.sv
// Directed bench for image_transmitter: SRAM returns (address - base) as
// pixel value, an SD stub answers each sd_write with a hold pulse, and the
// captured stream is checked against a BMP model and hand-computed bytes.
module tb_image_transmitter;

    typedef byte unsigned bq_t[$];

`ifdef IMG_TX_HEADER_EN
    localparam int HOFF = 54;
`else
    localparam int HOFF = 0;
`endif

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] img_width = '0;
    logic [15:0] img_height = '0;
    logic [15:0] base_address = '0;
    logic [31:0] w_start_addr = '0;
    logic        sram_read;
    logic [15:0] sram_address;
    logic [7:0]  sram_data = '0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        sd_write;
    logic [31:0] sd_block_addr;
    logic        sd_hold = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    int   total = 0;
    int   bad = 0;
    bq_t  cap;
    bq_t  exp_q;
    bq_t  cap4x2;
    logic [31:0] wr_addr[$];
    int   sram_reads = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    bit   bp_en = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0]  prev_byte = '0;
    int   hold_t = 0;
    logic [31:0] held_addr = '0;

    always #5 clk = ~clk;

    image_transmitter #(.BLOCK_BYTES(512), .ADDR_W(16)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .img_width(img_width), .img_height(img_height),
        .base_address(base_address), .w_start_addr(w_start_addr),
        .sram_read(sram_read), .sram_address(sram_address),
        .sram_data(sram_data), .out_byte(out_byte), .out_valid(out_valid),
        .out_ready(out_ready), .sd_write(sd_write),
        .sd_block_addr(sd_block_addr), .sd_hold(sd_hold), .busy(busy),
        .done(done), .error(error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({sram_read, sram_address, out_byte, out_valid, sd_write,
                    sd_block_addr, busy, done, error});
    endfunction

    function automatic logic [7:0] getb(input int i);
        if (i < cap.size()) return cap[i];
        return 8'hxx;
    endfunction

    function automatic int qdiff(input bq_t a, input bq_t b);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    task automatic push32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(v >> (8 * i)));
    endtask

    task automatic push16(input logic [15:0] v);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(v[15:8]);
    endtask

    // Reference BMP stream padded with zeros to a whole number of blocks.
    task automatic build_exp(input int w, input int h);
        int rb  = ((3 * w + 3) >> 2) << 2;
        int pad = rb - 3 * w;
        int img = rb * h;
        exp_q.delete();
`ifdef IMG_TX_HEADER_EN
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        push32(32'(54 + img)); push32(0); push32(54); push32(40);
        push32(32'(w)); push32(32'(h)); push16(1); push16(24);
        push32(0); push32(32'(img)); push32(2835); push32(2835);
        push32(0); push32(0);
`else
        if (img < 0) push16(0);
`endif
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++)
                for (int k = 0; k < 3; k++) exp_q.push_back(8'(r * w + c));
            for (int p = 0; p < pad; p++) exp_q.push_back(8'h00);
        end
        while (exp_q.size() % 512 != 0) exp_q.push_back(8'h00);
    endtask

    // SRAM stub: data valid the cycle after sram_read.
    initial forever begin
        @(posedge clk);
        if (sram_read) sram_data <= 8'(sram_address - base_address);
    end

    // Stream capture, stall stability, SD hold stub and event counters.
    initial forever begin
        @(negedge clk);
        if (prev_stall && n_rst)
            chk("stall_hold", 64'({out_valid, out_byte}), 64'({1'b1, prev_byte}));
        if (sram_read) sram_reads++;
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (!n_rst) begin
            hold_t = 0;
        end else if (hold_t != 0) begin
            chk("sd_addr_held", 64'(sd_block_addr), 64'(held_addr));
            chk("sd_write_in_flush", 64'(sd_write), 64'd0);
            hold_t++;
            if (hold_t == 7) hold_t = 0;
        end else if (sd_write) begin
            wr_addr.push_back(sd_block_addr);
            held_addr = sd_block_addr;
            hold_t = 1;
        end
        sd_hold = (hold_t >= 3 && hold_t <= 5);
        out_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (out_valid && out_ready) cap.push_back(out_byte);
        prev_stall = n_rst && out_valid && !out_ready;
        prev_byte  = out_byte;
    end

    task automatic run_img(input int w, input int h, input logic [15:0] base,
                           input logic [31:0] wst, input bit bp, input bit poke,
                           input string tag);
        int cyc = 0;
        int d0;
        int e0;
        @(negedge clk);
        cap.delete();
        wr_addr.delete();
        sram_reads = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        bp_en = bp;
        img_width = 16'(w);
        img_height = 16'(h);
        base_address = base;
        w_start_addr = wst;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        if (poke) begin
            repeat (30) @(negedge clk);
            img_width = 16'd0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            img_width = 16'(w);
        end
        while (done_cnt == d0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        @(negedge clk);
        bp_en = 1'b0;
        chk({tag, "_busy_after_done"}, 64'(busy), 64'd0);
        chk({tag, "_no_error"}, 64'(err_cnt - e0), 64'd0);
        build_exp(w, h);
        chk({tag, "_length"}, 64'(cap.size()), 64'(exp_q.size()));
        chk({tag, "_stream_diff_at"}, 64'(qdiff(cap, exp_q)), 64'(-1));
        chk({tag, "_sd_writes"}, 64'(wr_addr.size()), 64'(exp_q.size() / 512));
        foreach (wr_addr[i])
            chk({tag, "_sd_addr"}, 64'(wr_addr[i]), 64'(wst + 32'(i)));
        chk({tag, "_sram_reads"}, 64'(sram_reads), 64'(w * h));
    endtask

    initial begin
        int cyc;
        int d0;
        int r0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        n_rst = 1'b1;
        @(negedge clk);

        run_img(4, 2, 16'h0100, 32'd77, 1'b0, 1'b0, "img4x2");
        chk("4x2_pix0", 64'(getb(HOFF + 0)), 64'h00);
        chk("4x2_pix1", 64'(getb(HOFF + 3)), 64'h01);
        chk("4x2_row1", 64'(getb(HOFF + 12)), 64'h04);
        chk("4x2_last", 64'(getb(HOFF + 23)), 64'h07);
        chk("4x2_fill", 64'(getb(HOFF + 24)), 64'h00);
        chk("4x2_sd_addr0", 64'(wr_addr.size() > 0 ? wr_addr[0] : 32'hffffffff), 64'd77);
`ifdef IMG_TX_HEADER_EN
        chk("4x2_hdr_B", 64'(getb(0)), 64'h42);
        chk("4x2_fsize", 64'({getb(5), getb(4), getb(3), getb(2)}), 64'h0000004E);
`endif
        cap4x2 = cap;

        run_img(3, 1, 16'h0000, 32'd10, 1'b0, 1'b0, "img3x1");
        chk("3x1_pix2", 64'(getb(HOFF + 8)), 64'h02);
        chk("3x1_pad", 64'({getb(HOFF + 9), getb(HOFF + 10), getb(HOFF + 11)}), 64'h0);
`ifdef IMG_TX_HEADER_EN
        chk("3x1_imgbytes", 64'({getb(37), getb(36), getb(35), getb(34)}), 64'h0000000C);
`endif

        run_img(3, 2, 16'h0040, 32'd20, 1'b0, 1'b0, "img3x2");
        chk("3x2_row1_first", 64'(getb(HOFF + 12)), 64'h03);
        chk("3x2_row1_last", 64'(getb(HOFF + 20)), 64'h05);
        chk("3x2_pad_row0", 64'(getb(HOFF + 9)), 64'h00);

        run_img(100, 2, 16'h0200, 32'd5000, 1'b0, 1'b0, "img100x2");
        chk("100x2_writes", 64'(wr_addr.size()), 64'd2);
        chk("100x2_addr1", 64'(wr_addr.size() > 1 ? wr_addr[1] : 32'hffffffff), 64'd5001);
`ifdef IMG_TX_HEADER_EN
        chk("100x2_byte512", 64'(getb(512)), 64'd152);
`else
        chk("100x2_byte512", 64'(getb(512)), 64'd170);
`endif
        chk("100x2_row1", 64'(getb(HOFF + 300)), 64'd100);

        // 1-pixel rows: 3 pixel bytes + 1 pad byte; 128 rows fill one block exactly.
        run_img(1, 128, 16'h0000, 32'd900, 1'b0, 1'b0, "img1x128");
        chk("1x128_writes", 64'(wr_addr.size()), 64'(HOFF == 0 ? 1 : 2));
        chk("1x128_pad", 64'(getb(HOFF + 3)), 64'h00);
        chk("1x128_px1", 64'(getb(HOFF + 4)), 64'h01);
        chk("1x128_px127", 64'(getb(HOFF + 508)), 64'd127);

        run_img(4, 2, 16'h0100, 32'd77, 1'b1, 1'b1, "bp4x2");
        chk("bp_same_as_4x2", 64'(qdiff(cap, cap4x2)), 64'(-1));

        // Zero-dimension start.
        @(negedge clk);
        r0 = sram_reads;
        img_width = 16'd0;
        img_height = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_w_error", 64'(error), 64'd1);
        chk("zero_w_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("zero_w_error_pulse", 64'(error), 64'd0);
        img_width = 16'd4;
        img_height = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_h_error", 64'(error), 64'd1);
        repeat (5) @(negedge clk);
        chk("zero_dim_no_read", 64'(sram_reads - r0), 64'd0);
        chk("zero_dim_idle", 64'(busy), 64'd0);

        // Reset in the middle of pixel emission.
        cap.delete();
        wr_addr.delete();
        img_width = 16'd100;
        img_height = 16'd2;
        base_address = 16'h0200;
        w_start_addr = 32'd5000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(out_valid && cap.size() >= HOFF + 30) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reached_emit", 64'(out_valid), 64'd1);
        chk("rst_no_flush_yet", 64'(wr_addr.size()), 64'd0);
        n_rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", outs(), 64'd0);
        d0 = done_cnt;
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rst_no_sd_write", 64'(wr_addr.size()), 64'd0);

        run_img(4, 2, 16'h0100, 32'd77, 1'b0, 1'b0, "after_rst4x2");
        chk("after_rst_same_as_4x2", 64'(qdiff(cap, cap4x2)), 64'(-1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
